core_fetch: RTL and testbench

- Instruction fetch stage for the RV32I core; sits directly upstream of core_decode and produces the 32-bit instruction word it consumes.
- Holds the PC, issues in-order requests to instruction memory with a valid/ready handshake, and buffers responses in a small FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Execute redirects fetch on taken branches and jumps; the redirect flushes the FIFO and discards stale in-flight responses.

---
 rtl/core_fetch.sv | 107 ++++++++++
 tb/tb_core_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch.sv
// Instruction fetch stage: PC, credit-limited in-order instruction memory requests,
// a small response FIFO toward decode, and redirect handling that drops stale responses.
module core_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [31:0] IMEM_REQ_ADDR,
  input  logic        IMEM_RSP_VALID,
  input  logic [31:0] IMEM_RSP_DATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST,
  output logic [31:0] INST_PC
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   inst_mem [BUF_DEPTH];
  logic [31:0]   pc_mem   [BUF_DEPTH];

  logic [CW:0] credit_sum;
  logic        req_fire;
  logic        rsp_live;
  logic        rsp_drop;
  logic        push;
  logic        pop;

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both
  // high; VALID never waits on READY, and once raised the payload holds until the
  // transfer, except that REDIRECT or RST may withdraw a pending request.
  always_comb begin
    credit_sum     = {1'b0, outstanding} + {1'b0, count} + {1'b0, drop_cnt};
    IMEM_REQ_VALID = !RST && !REDIRECT && (credit_sum < {1'b0, DEPTH_C});
    IMEM_REQ_ADDR  = pc;
    INST_VALID     = (count != '0) && !REDIRECT;
    INST           = (count != '0) ? inst_mem[rd_ptr] : NOP;
    INST_PC        = (count != '0) ? pc_mem[rd_ptr] : '0;
    req_fire       = IMEM_REQ_VALID && IMEM_REQ_READY;
    rsp_drop       = IMEM_RSP_VALID && (drop_cnt != '0);
    rsp_live       = IMEM_RSP_VALID && (drop_cnt == '0);
    push           = rsp_live && !REDIRECT;
    pop            = INST_VALID && INST_READY;
  end

  // outstanding counts only live requests; drop_cnt counts stale ones still in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (REDIRECT) begin
      pc          <= REDIRECT_PC & ~32'h3;
      rsp_pc      <= REDIRECT_PC & ~32'h3;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + outstanding - (IMEM_RSP_VALID ? ONE_C : '0);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      if (push) begin
        inst_mem[wr_ptr] <= IMEM_RSP_DATA;
        pc_mem[wr_ptr]   <= rsp_pc;
        wr_ptr           <= wr_ptr + ONE_A;
        rsp_pc           <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + ONE_A;
      if (rsp_drop) drop_cnt <= drop_cnt - ONE_C;
      case ({req_fire, rsp_live})
        2'b10:   outstanding <= outstanding + ONE_C;
        2'b01:   outstanding <= outstanding - ONE_C;
        default: outstanding <= outstanding;
      endcase
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Credits bound buffered plus in-flight words, so a full FIFO never sees a push.
  always_ff @(posedge CLK) begin
    if (!RST && push) assert (count != DEPTH_C);
  end
endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: a latency-programmable in-order memory model and a
// scoreboard of {pc, word} expected at decode, flushed on redirect and reset.
module tb_core_fetch;
  logic        CLK;
  logic        RST;
  logic        IMEM_REQ_VALID;
  logic        IMEM_REQ_READY;
  logic [31:0] IMEM_REQ_ADDR;
  logic        IMEM_RSP_VALID;
  logic [31:0] IMEM_RSP_DATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        INST_VALID;
  logic        INST_READY;
  logic [31:0] INST;
  logic [31:0] INST_PC;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  logic [63:0] exp_q[$];
  int          mem_lat = 1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_fire = 0;
  int          n_pop = 0;
  int          base;

  core_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_REQ_VALID(IMEM_REQ_VALID), .IMEM_REQ_READY(IMEM_REQ_READY),
    .IMEM_REQ_ADDR(IMEM_REQ_ADDR),
    .IMEM_RSP_VALID(IMEM_RSP_VALID), .IMEM_RSP_DATA(IMEM_RSP_DATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .INST_VALID(INST_VALID), .INST_READY(INST_READY),
    .INST(INST), .INST_PC(INST_PC)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score the cycle's transfers, advance, then drive the memory response.
  task automatic tick();
    logic        fire;
    logic        pop;
    logic        rst_s;
    logic [63:0] e;
    #1;
    fire  = IMEM_REQ_VALID && IMEM_REQ_READY;
    pop   = INST_VALID && INST_READY;
    rst_s = RST;
    if (pop) begin
      n_pop++;
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("inst_pc", INST_PC, e[63:32]);
        check("inst", INST, e[31:0]);
      end
    end
    if (RST || REDIRECT) exp_q.delete();
    if (REDIRECT) check("redirect_noreq", 32'(IMEM_REQ_VALID), 32'd0);
    if (fire) begin
      n_fire++;
      mem_q.push_back('{addr: IMEM_REQ_ADDR, due: cyc + mem_lat});
      if (!RST && !REDIRECT) exp_q.push_back({IMEM_REQ_ADDR, IMEM_REQ_ADDR ^ SALT});
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (rst_s) mem_q.delete();
    IMEM_RSP_VALID = 1'b0;
    IMEM_RSP_DATA  = '0;
    if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      IMEM_RSP_VALID = 1'b1;
      IMEM_RSP_DATA  = mem_q[0].addr ^ SALT;
      void'(mem_q.pop_front());
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    #1;
    while (!IMEM_REQ_VALID && n < max) begin
      tick();
      n++;
      #1;
    end
    check("wait_req_timeout", 32'(IMEM_REQ_VALID), 32'd1);
  endtask

  task automatic wait_inst(input int max);
    int n = 0;
    #1;
    while (!INST_VALID && n < max) begin
      tick();
      n++;
      #1;
    end
    check("wait_inst_timeout", 32'(INST_VALID), 32'd1);
  endtask

  initial begin
    RST = 1'b1; IMEM_REQ_READY = 1'b1; IMEM_RSP_VALID = 1'b0; IMEM_RSP_DATA = '0;
    REDIRECT = 1'b0; REDIRECT_PC = '0; INST_READY = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_inst_valid", 32'(INST_VALID), 32'd0);
    check("rst_inst", INST, NOP);
    check("rst_inst_pc", INST_PC, 32'd0);
    check("rst_req_valid", 32'(IMEM_REQ_VALID), 32'd0);

    // Sequential fetch, 1-cycle memory
    RST = 1'b0; INST_READY = 1'b1;
    #1;
    check("seq_first_req", {31'b0, IMEM_REQ_VALID}, 32'd1);
    check("seq_first_addr", IMEM_REQ_ADDR, 32'h0);
    tick();
    #1 check("seq_lat_n1", 32'(INST_VALID), 32'd0);
    tick();
    #1 check("seq_lat_n2", 32'(INST_VALID), 32'd1);
    check("seq_pc0", INST_PC, 32'h0);
    tick();
    #1 check("seq_valid_n3", 32'(INST_VALID), 32'd1);
    check("seq_pc4", INST_PC, 32'h4);
    for (int i = 0; i < 8; i++) tick();

    // Backpressure
    do_reset();
    INST_READY = 1'b0;
    base = n_fire;
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("bp_fires", 32'(n_fire - base), 32'd2);
    check("bp_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
    check("bp_head_pc", INST_PC, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check("bp_fires_hold", 32'(n_fire - base), 32'd2);
    INST_READY = 1'b1;
    base = n_pop;
    for (int i = 0; i < 12; i++) tick();
    check("bp_drained", 32'(n_pop - base >= 3), 32'd1);

    // Redirect with stale traffic, 3-cycle memory
    do_reset();
    mem_lat = 3;
    tick();
    tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    #1;
    check("stale_redir_inst_valid", 32'(INST_VALID), 32'd0);
    tick();
    REDIRECT = 1'b0;
    wait_req(10);
    check("stale_next_addr", IMEM_REQ_ADDR, 32'h100);
    wait_inst(12);
    check("stale_first_pc", INST_PC, 32'h100);
    for (int i = 0; i < 10; i++) tick();

    // Misaligned target and memory stall
    do_reset();
    mem_lat = 1;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0102;
    tick();
    REDIRECT = 1'b0; IMEM_REQ_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", 32'(IMEM_REQ_VALID), 32'd1);
      check("stall_addr", IMEM_REQ_ADDR, 32'h100);
      tick();
    end
    IMEM_REQ_READY = 1'b1;
    wait_inst(6);
    check("stall_first_pc", INST_PC, 32'h100);
    check("stall_first_inst", INST, 32'h100 ^ SALT);
    for (int i = 0; i < 4; i++) tick();

    // Redirect coincident with a response and a pop
    do_reset();
    INST_READY = 1'b1;
    tick();
    tick();
    #1 check("coinc_pre_valid", 32'(INST_VALID), 32'd1);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
    #1 check("coinc_inst_valid", 32'(INST_VALID), 32'd0);
    tick();
    REDIRECT = 1'b0;
    #1;
    check("coinc_fifo_empty", 32'(INST_VALID), 32'd0);
    check("coinc_req_valid", 32'(IMEM_REQ_VALID), 32'd1);
    check("coinc_req_addr", IMEM_REQ_ADDR, 32'h200);
    wait_inst(6);
    check("coinc_first_pc", INST_PC, 32'h200);
    for (int i = 0; i < 4; i++) tick();

    // Reset mid-stream with a full FIFO
    do_reset();
    INST_READY = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #1;
    check("full_pre_valid", 32'(INST_VALID), 32'd1);
    check("full_pre_noreq", 32'(IMEM_REQ_VALID), 32'd0);
    RST = 1'b1;
    tick();
    #1;
    check("midrst_inst_valid", 32'(INST_VALID), 32'd0);
    check("midrst_inst", INST, NOP);
    check("midrst_inst_pc", INST_PC, 32'd0);
    check("midrst_req_valid", 32'(IMEM_REQ_VALID), 32'd0);
    RST = 1'b0;
    #1;
    check("midrst_resume_valid", 32'(IMEM_REQ_VALID), 32'd1);
    check("midrst_resume_addr", IMEM_REQ_ADDR, 32'h0);
    INST_READY = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // PC wrap
    do_reset();
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC;
    tick();
    REDIRECT = 1'b0;
    #1;
    check("wrap_first_addr", IMEM_REQ_ADDR, 32'hFFFF_FFFC);
    tick();
    #1;
    check("wrap_req_valid", 32'(IMEM_REQ_VALID), 32'd1);
    check("wrap_addr", IMEM_REQ_ADDR, 32'h0);
    wait_inst(6);
    check("wrap_first_pc", INST_PC, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
